// File: rtl/id_ctrl_pipe_if.sv
// id_ctrl_pipe_if: ID-side request signals and the registered EX control bundle
// of id_ctrl_pipe.
//   master: ID stage / environment (drives instr_valid, instruction, stall_in, flush)
//   slave : id_ctrl_pipe (drives id_ready and every ex_* signal)
interface id_ctrl_pipe_if;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        stall_in;
  logic        flush;
  logic        id_ready;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic        ex_reg_write_en;
  logic [2:0]  ex_mem_write;
  logic [3:0]  ex_mem_read;
  logic [3:0]  ex_branch_jump;
  logic [3:0]  ex_imm_sel;
  logic        ex_data1_alu_sel;
  logic        ex_data2_alu_sel;
  logic [1:0]  ex_wb_sel;
  logic        ex_busy;
  logic        ex_illegal;

  modport master (
    output instr_valid, instruction, stall_in, flush,
    input  id_ready, ex_valid, ex_alu_op, ex_reg_write_en, ex_mem_write, ex_mem_read,
           ex_branch_jump, ex_imm_sel, ex_data1_alu_sel, ex_data2_alu_sel, ex_wb_sel,
           ex_busy, ex_illegal
  );

  modport slave (
    input  instr_valid, instruction, stall_in, flush,
    output id_ready, ex_valid, ex_alu_op, ex_reg_write_en, ex_mem_write, ex_mem_read,
           ex_branch_jump, ex_imm_sel, ex_data1_alu_sel, ex_data2_alu_sel, ex_wb_sel,
           ex_busy, ex_illegal
  );
endinterface

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: RV32I(M) control decode plus the ID/EX control pipeline register.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - id_ctrl_pipe_if.slave: ID request (instr_valid, instruction, stall_in, flush),
//           id_ready back-pressure, registered ex_* control bundle, ex_busy, ex_illegal
// Build option: define ID_CTRL_MEXT_EN to decode funct7=0000001 R-type as M-extension ops
// and add the MWAIT/DWAIT occupancy FSM; otherwise those encodings are illegal and
// ex_busy is tied low.
// Encodings: alu ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9, MUL..REMU 10..17;
// mem_read {1,funct3}; mem_write funct3+1; branch {1,funct3}, JAL 2, JALR 3;
// imm none0 I1 S2 B3 U4 J5; data1 1=PC; data2 1=imm; wb ALU0 MEM1 PC+4 2 IMM3.
module id_ctrl_pipe #(
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  id_ctrl_pipe_if.slave bus
);

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [4:0] AluAdd = 5'd0, AluSub = 5'd1, AluSll = 5'd2, AluSlt = 5'd3;
  localparam logic [4:0] AluSltu = 5'd4, AluXor = 5'd5, AluSrl = 5'd6, AluSra = 5'd7;
  localparam logic [4:0] AluOr = 5'd8, AluAnd = 5'd9, AluMul = 5'd10;

  localparam logic [3:0] ImmI = 4'd1, ImmS = 4'd2, ImmB = 4'd3, ImmU = 4'd4, ImmJ = 4'd5;
  localparam logic [1:0] WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2, WbImm = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu_op;
    logic       reg_write_en;
    logic [2:0] mem_write;
    logic [3:0] mem_read;
    logic [3:0] branch_jump;
    logic [3:0] imm_sel;
    logic       data1_alu_sel;
    logic       data2_alu_sel;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  ctrl_t      dec, ex_q, ex_d;
  logic       legal, busy;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];

  logic unused_instr;
  assign unused_instr = ^{bus.instruction[24:15], bus.instruction[11:7]};

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'd0:    op = alt ? AluSub : AluAdd;
      3'd1:    op = AluSll;
      3'd2:    op = AluSlt;
      3'd3:    op = AluSltu;
      3'd4:    op = AluXor;
      3'd5:    op = alt ? AluSra : AluSrl;
      3'd6:    op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

`ifdef ID_CTRL_MEXT_EN
  logic is_mul, is_div;
`endif

  always_comb begin
    dec   = '0;
    legal = 1'b1;
`ifdef ID_CTRL_MEXT_EN
    is_mul = 1'b0;
    is_div = 1'b0;
`endif
    case (opcode)
      OpRType: begin
        dec.reg_write_en = 1'b1;
        dec.wb_sel       = WbAlu;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = base_alu(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          dec.alu_op = base_alu(funct3, 1'b1);
        end else if (funct7 == 7'b0000001) begin
`ifdef ID_CTRL_MEXT_EN
          dec.alu_op = AluMul + {2'b00, funct3};
          is_mul     = !funct3[2];
          is_div     = funct3[2];
`else
          legal = 1'b0;
`endif
        end else begin
          legal = 1'b0;
        end
      end
      OpIType: begin
        dec.reg_write_en  = 1'b1;
        dec.imm_sel       = ImmI;
        dec.data2_alu_sel = 1'b1;
        // Shift-immediates reuse funct7 as a sub-opcode; other funct3 values carry imm bits.
        if (funct3 == 3'd1) begin
          legal      = (funct7 == 7'b0000000);
          dec.alu_op = AluSll;
        end else if (funct3 == 3'd5) begin
          legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          dec.alu_op = base_alu(funct3, funct7[5]);
        end else begin
          dec.alu_op = base_alu(funct3, 1'b0);
        end
      end
      OpLoad: begin
        legal             = (funct3 != 3'd3) && (funct3 <= 3'd5);
        dec.reg_write_en  = 1'b1;
        dec.mem_read      = {1'b1, funct3};
        dec.imm_sel       = ImmI;
        dec.data2_alu_sel = 1'b1;
        dec.wb_sel        = WbMem;
      end
      OpStore: begin
        legal             = (funct3 <= 3'd2);
        dec.mem_write     = funct3 + 3'd1;
        dec.imm_sel       = ImmS;
        dec.data2_alu_sel = 1'b1;
      end
      OpBranch: begin
        legal           = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.branch_jump = {1'b1, funct3};
        dec.imm_sel     = ImmB;
        dec.alu_op      = AluSub;
      end
      OpJal: begin
        dec.reg_write_en  = 1'b1;
        dec.branch_jump   = 4'd2;
        dec.imm_sel       = ImmJ;
        dec.data1_alu_sel = 1'b1;
        dec.data2_alu_sel = 1'b1;
        dec.wb_sel        = WbPc4;
      end
      OpJalr: begin
        legal             = (funct3 == 3'd0);
        dec.reg_write_en  = 1'b1;
        dec.branch_jump   = 4'd3;
        dec.imm_sel       = ImmI;
        dec.data2_alu_sel = 1'b1;
        dec.wb_sel        = WbPc4;
      end
      OpLui: begin
        dec.reg_write_en  = 1'b1;
        dec.imm_sel       = ImmU;
        dec.data2_alu_sel = 1'b1;
        dec.wb_sel        = WbImm;
      end
      OpAuipc: begin
        dec.reg_write_en  = 1'b1;
        dec.imm_sel       = ImmU;
        dec.data1_alu_sel = 1'b1;
        dec.data2_alu_sel = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal slots carry the bubble bundle but stay valid so EX can raise a trap.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
`ifdef ID_CTRL_MEXT_EN
      is_mul = 1'b0;
      is_div = 1'b0;
`endif
    end
    dec.valid = 1'b1;
  end

`ifdef ID_CTRL_MEXT_EN
  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  typedef enum logic [1:0] {StIdle, StMWait, StDWait} state_e;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign busy = (state_q != StIdle);
`else
  logic unused_cfg;
  assign unused_cfg = ^{MUL_CYCLES, DIV_CYCLES};
  assign busy       = 1'b0;
`endif

  always_comb begin
    ex_d = ex_q;
`ifdef ID_CTRL_MEXT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
`endif
    if (bus.flush) begin
      ex_d = '0;
`ifdef ID_CTRL_MEXT_EN
      state_d = StIdle;
      cnt_d   = '0;
`endif
    end else if (busy) begin
`ifdef ID_CTRL_MEXT_EN
      if (cnt_q == '0) state_d = StIdle;
      else             cnt_d   = cnt_q - 1'b1;
`endif
    end else if (!bus.stall_in) begin
      ex_d = bus.instr_valid ? dec : '0;
`ifdef ID_CTRL_MEXT_EN
      // Counter holds remaining busy edges minus one, so N-cycle ops stall ID for N-1.
      if (bus.instr_valid && is_mul && MUL_CYCLES > 1) begin
        state_d = StMWait;
        cnt_d   = CntW'(MUL_CYCLES - 2);
      end else if (bus.instr_valid && is_div && DIV_CYCLES > 1) begin
        state_d = StDWait;
        cnt_d   = CntW'(DIV_CYCLES - 2);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
`ifdef ID_CTRL_MEXT_EN
      state_q <= StIdle;
      cnt_q   <= '0;
`endif
    end else begin
      ex_q <= ex_d;
`ifdef ID_CTRL_MEXT_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.id_ready         = !bus.stall_in && !busy;
  assign bus.ex_busy          = busy;
  assign bus.ex_valid         = ex_q.valid;
  assign bus.ex_alu_op        = ex_q.alu_op;
  assign bus.ex_reg_write_en  = ex_q.reg_write_en;
  assign bus.ex_mem_write     = ex_q.mem_write;
  assign bus.ex_mem_read      = ex_q.mem_read;
  assign bus.ex_branch_jump   = ex_q.branch_jump;
  assign bus.ex_imm_sel       = ex_q.imm_sel;
  assign bus.ex_data1_alu_sel = ex_q.data1_alu_sel;
  assign bus.ex_data2_alu_sel = ex_q.data2_alu_sel;
  assign bus.ex_wb_sel        = ex_q.wb_sel;
  assign bus.ex_illegal       = ex_q.illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Self-checking bench for id_ctrl_pipe: decode vector table, hand-written multi-cycle
// sequences and randomized traffic against an occupancy-based reference model.
module tb_id_ctrl_pipe;
  localparam int unsigned MulC = 2;
  localparam int unsigned DivC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  id_ctrl_pipe_if bus ();

  id_ctrl_pipe #(.MUL_CYCLES(MulC), .DIV_CYCLES(DivC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu;
    logic       rw;
    logic [2:0] mw;
    logic [3:0] mr;
    logic [3:0] bj;
    logic [3:0] imm;
    logic       d1;
    logic       d2;
    logic [1:0] wb;
    logic       ill;
  } bundle_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] mask;
    bundle_t     exp;
    int          kind;  // 0 single-cycle, 1 MUL-class, 2 DIV-class
  } vec_t;

  localparam logic [6:0] R = 7'h33, I = 7'h13, L = 7'h03, S = 7'h23, B = 7'h63;
  localparam logic [31:0] MR = 32'hFE00707F, MF3 = 32'h0000707F, MOP = 32'h0000007F;

  vec_t    vecs[$];
  int      errors = 0;
  int      checks = 0;
  bundle_t m_ex;
  int      m_left;
  int      busy_seen;

  function automatic bundle_t mk(logic [4:0] alu, logic rw, logic [2:0] mw, logic [3:0] mr,
                                 logic [3:0] bj, logic [3:0] imm, logic d1, logic d2,
                                 logic [1:0] wb);
    bundle_t b;
    b = '{valid: 1'b1, alu: alu, rw: rw, mw: mw, mr: mr, bj: bj, imm: imm, d1: d1, d2: d2,
          wb: wb, ill: 1'b0};
    return b;
  endfunction

  function automatic bundle_t ill_b();
    bundle_t b;
    b       = '0;
    b.valid = 1'b1;
    b.ill   = 1'b1;
    return b;
  endfunction

  function automatic void add(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] mask, bundle_t e, int kind);
    vec_t v;
    v.name  = n;
    v.instr = {f7, 10'b0, f3, 5'b0, op};
    v.mask  = mask;
    v.exp   = e;
    v.kind  = kind;
    vecs.push_back(v);
  endfunction

  function automatic vec_t find(string n);
    foreach (vecs[i]) if (vecs[i].name == n) return vecs[i];
    return vecs[0];
  endfunction

  function automatic int occ(int kind);
`ifdef ID_CTRL_MEXT_EN
    if (kind == 1) return int'(MulC);
    if (kind == 2) return int'(DivC);
`endif
    return 1;
  endfunction

  function automatic bundle_t dut_bundle();
    return {bus.ex_valid, bus.ex_alu_op, bus.ex_reg_write_en, bus.ex_mem_write,
            bus.ex_mem_read, bus.ex_branch_jump, bus.ex_imm_sel, bus.ex_data1_alu_sel,
            bus.ex_data2_alu_sel, bus.ex_wb_sel, bus.ex_illegal};
  endfunction

  task automatic check_bit(string n, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", n, got, exp, $time);
    end
  endtask

  task automatic check_int(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic check_bundle(string n, bundle_t got, bundle_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h at %0t", n, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check id_ready/busy, advance model at posedge, check EX.
  task automatic step(string n, logic valid, vec_t v, logic stall, logic fl);
    @(negedge clk);
    bus.instr_valid = valid;
    bus.instruction = (v.instr & v.mask) | ($urandom() & ~v.mask);
    bus.stall_in    = stall;
    bus.flush       = fl;
    #1;
    check_bit({n, " id_ready"}, bus.id_ready, !stall && m_left == 0);
    check_bit({n, " busy_pre"}, bus.ex_busy, m_left != 0);
    @(posedge clk);
    if (fl) begin
      m_ex   = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (!stall) begin
      m_ex   = valid ? v.exp : '0;
      m_left = valid ? occ(v.kind) - 1 : 0;
    end
    #1;
    check_bundle({n, " ex"}, dut_bundle(), m_ex);
    check_bit({n, " busy"}, bus.ex_busy, m_left != 0);
    if (bus.ex_busy) busy_seen++;
  endtask

  task automatic idle(string n);
    step(n, 1'b0, vecs[0], 1'b0, 1'b0);
  endtask

  task automatic drain(string n);
    for (int k = 0; k < 40 && m_left > 0; k++) idle(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_bundle("async_reset ex", dut_bundle(), '0);
    check_bit("async_reset id_ready", bus.id_ready, 1'b1);
    check_bit("async_reset busy", bus.ex_busy, 1'b0);
    @(posedge clk);
    #1;
    check_bundle("held_reset ex", dut_bundle(), '0);
    @(negedge clk);
    reset  = 1'b1;
    m_ex   = '0;
    m_left = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    edges;
    vec_t  addv;
    string seq[8];

    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.stall_in    = 1'b0;
    bus.flush       = 1'b0;
    m_ex            = '0;
    m_left          = 0;
    busy_seen       = 0;

    add("ADD",   R, 3'd0, 7'h00, MR,  mk(5'd0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SUB",   R, 3'd0, 7'h20, MR,  mk(5'd1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SLL",   R, 3'd1, 7'h00, MR,  mk(5'd2, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SLT",   R, 3'd2, 7'h00, MR,  mk(5'd3, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SLTU",  R, 3'd3, 7'h00, MR,  mk(5'd4, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("XOR",   R, 3'd4, 7'h00, MR,  mk(5'd5, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SRL",   R, 3'd5, 7'h00, MR,  mk(5'd6, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("SRA",   R, 3'd5, 7'h20, MR,  mk(5'd7, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("OR",    R, 3'd6, 7'h00, MR,  mk(5'd8, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("AND",   R, 3'd7, 7'h00, MR,  mk(5'd9, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    add("ADDI",  I, 3'd0, 7'h00, MF3, mk(5'd0, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("SLTI",  I, 3'd2, 7'h00, MF3, mk(5'd3, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("XORI",  I, 3'd4, 7'h00, MF3, mk(5'd5, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("ANDI",  I, 3'd7, 7'h00, MF3, mk(5'd9, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("SLLI",  I, 3'd1, 7'h00, MR,  mk(5'd2, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("SRLI",  I, 3'd5, 7'h00, MR,  mk(5'd6, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("SRAI",  I, 3'd5, 7'h20, MR,  mk(5'd7, 1, 0, 0, 0, 1, 0, 1, 0), 0);
    add("LW",    L, 3'd2, 7'h00, MF3, mk(5'd0, 1, 0, 4'hA, 0, 1, 0, 1, 1), 0);
    add("LBU",   L, 3'd4, 7'h00, MF3, mk(5'd0, 1, 0, 4'hC, 0, 1, 0, 1, 1), 0);
    add("SW",    S, 3'd2, 7'h00, MF3, mk(5'd0, 0, 3, 0, 0, 2, 0, 1, 0), 0);
    add("SB",    S, 3'd0, 7'h00, MF3, mk(5'd0, 0, 1, 0, 0, 2, 0, 1, 0), 0);
    add("BEQ",   B, 3'd0, 7'h00, MF3, mk(5'd1, 0, 0, 0, 4'h8, 3, 0, 0, 0), 0);
    add("BGEU",  B, 3'd7, 7'h00, MF3, mk(5'd1, 0, 0, 0, 4'hF, 3, 0, 0, 0), 0);
    add("JAL",   7'h6F, 3'd0, 7'h00, MOP, mk(5'd0, 1, 0, 0, 4'd2, 5, 1, 1, 2), 0);
    add("JALR",  7'h67, 3'd0, 7'h00, MF3, mk(5'd0, 1, 0, 0, 4'd3, 1, 0, 1, 2), 0);
    add("LUI",   7'h37, 3'd0, 7'h00, MOP, mk(5'd0, 1, 0, 0, 0, 4, 0, 1, 3), 0);
    add("AUIPC", 7'h17, 3'd0, 7'h00, MOP, mk(5'd0, 1, 0, 0, 0, 4, 1, 1, 0), 0);
    add("ILL_OP",   7'h7F, 3'd0, 7'h00, MOP, ill_b(), 0);
    add("ILL_R",    R, 3'd1, 7'h20, MR,  ill_b(), 0);
    add("ILL_F7",   R, 3'd0, 7'h10, MR,  ill_b(), 0);
    add("ILL_LD",   L, 3'd3, 7'h00, MF3, ill_b(), 0);
    add("ILL_ST",   S, 3'd3, 7'h00, MF3, ill_b(), 0);
    add("ILL_BR",   B, 3'd2, 7'h00, MF3, ill_b(), 0);
    add("ILL_JALR", 7'h67, 3'd1, 7'h00, MF3, ill_b(), 0);
    add("ILL_SLLI", I, 3'd1, 7'h20, MR,  ill_b(), 0);
`ifdef ID_CTRL_MEXT_EN
    add("MUL",  R, 3'd0, 7'h01, MR, mk(5'd10, 1, 0, 0, 0, 0, 0, 0, 0), 1);
    add("MULH", R, 3'd1, 7'h01, MR, mk(5'd11, 1, 0, 0, 0, 0, 0, 0, 0), 1);
    add("DIV",  R, 3'd4, 7'h01, MR, mk(5'd14, 1, 0, 0, 0, 0, 0, 0, 0), 2);
    add("REMU", R, 3'd7, 7'h01, MR, mk(5'd17, 1, 0, 0, 0, 0, 0, 0, 0), 2);
`else
    add("MUL",  R, 3'd0, 7'h01, MR, ill_b(), 0);
    add("MULH", R, 3'd1, 7'h01, MR, ill_b(), 0);
    add("DIV",  R, 3'd4, 7'h01, MR, ill_b(), 0);
    add("REMU", R, 3'd7, 7'h01, MR, ill_b(), 0);
`endif

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_bundle("por ex", dut_bundle(), '0);
    check_bit("por id_ready", bus.id_ready, 1'b1);
    check_bit("por busy", bus.ex_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Decode table: every vector loaded once, drained if it occupies EX.
    foreach (vecs[i]) begin
      step(vecs[i].name, 1'b1, vecs[i], 1'b0, 1'b0);
      drain({vecs[i].name, "_drain"});
    end

    // Reset mid-stream (mid-DWAIT when M ops exist), then first ADD after release.
    addv = find("ADD");
    step("pre_rst_add", 1'b1, addv, 1'b0, 1'b0);
    step("pre_rst_div", 1'b1, find("DIV"), 1'b0, 1'b0);
    idle("pre_rst_idle");
    do_reset();
    step("post_rst_add", 1'b1, addv, 1'b0, 1'b0);
    check_bit("post_rst_add rw", bus.ex_reg_write_en, 1'b1);
    check_bit("post_rst_add valid", bus.ex_valid, 1'b1);

    // Back-to-back RV32I mix.
    seq = '{"ADD", "ADDI", "LW", "SW", "BEQ", "JAL", "LUI", "AUIPC"};
    foreach (seq[i]) step({"b2b_", seq[i]}, 1'b1, find(seq[i]), 1'b0, 1'b0);

    // Stall for 3 cycles after LW is loaded; SW enters afterwards.
    step("stall_lw", 1'b1, find("LW"), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("stall_hold", 1'b1, find("SW"), 1'b1, 1'b0);
      check_bundle("stall_hold lw", dut_bundle(), find("LW").exp);
    end
    step("stall_release", 1'b1, find("SW"), 1'b0, 1'b0);
    check_bundle("stall_release sw", dut_bundle(), find("SW").exp);

    // DIV followed by ADD held at ID: count edges until ADD reaches EX.
    busy_seen = 0;
    step("div_load", 1'b1, find("DIV"), 1'b0, 1'b0);
    edges = 0;
    do begin
      step("div_then_add", 1'b1, addv, 1'b0, 1'b0);
      edges++;
    end while (dut_bundle() !== addv.exp && edges < 12);
`ifdef ID_CTRL_MEXT_EN
    check_int("div_to_add edges", edges, int'(DivC));
    check_int("div busy cycles", busy_seen, int'(DivC) - 1);
`else
    check_int("div_to_add edges", edges, 1);
    check_int("div busy cycles", busy_seen, 0);
`endif

    // Flush on the second busy cycle of a DIV aborts it.
    step("flush_div_load", 1'b1, find("DIV"), 1'b0, 1'b0);
    idle("flush_div_busy1");
    step("flush_div_busy2", 1'b1, addv, 1'b0, 1'b1);
    check_bundle("flush bubble", dut_bundle(), '0);
    check_bit("flush busy", bus.ex_busy, 1'b0);
    check_bit("flush id_ready", bus.id_ready, 1'b1);
    step("after_flush_add", 1'b1, addv, 1'b0, 1'b0);

    // Flush and stall together: flush wins.
    step("fs_add", 1'b1, addv, 1'b0, 1'b0);
    step("fs_both", 1'b1, find("SUB"), 1'b1, 1'b1);
    check_bundle("flush_over_stall", dut_bundle(), '0);

    // Illegal opcode, and MUL occupancy/legality.
    step("ill_op", 1'b1, find("ILL_OP"), 1'b0, 1'b0);
    check_bit("ill_op illegal", bus.ex_illegal, 1'b1);
    check_bit("ill_op valid", bus.ex_valid, 1'b1);
    check_bit("ill_op rw", bus.ex_reg_write_en, 1'b0);
    check_int("ill_op mw", int'(bus.ex_mem_write), 0);
    busy_seen = 0;
    step("mul_load", 1'b1, find("MUL"), 1'b0, 1'b0);
`ifdef ID_CTRL_MEXT_EN
    check_bit("mul illegal", bus.ex_illegal, 1'b0);
`else
    check_bit("mul illegal", bus.ex_illegal, 1'b1);
`endif
    for (int k = 0; k < 3; k++) idle("mul_after");
`ifdef ID_CTRL_MEXT_EN
    check_int("mul busy cycles", busy_seen, int'(MulC) - 1);
`else
    check_int("mul busy cycles", busy_seen, 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      int unsigned idx;
      idx = $urandom_range(vecs.size() - 1);
      step({"rand_", vecs[idx].name}, ($urandom_range(9) < 8), vecs[idx],
           ($urandom_range(4) == 0), ($urandom_range(11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
